// File: rtl/uart_pkg.sv
// Shared UART definitions used by the TX serializer and the RX side.
// FSM encodings, data width, default baud divisor and idle line level.
package uart_pkg;

  localparam int unsigned UART_DATA_BITS        = 8;
  localparam int unsigned UART_DEFAULT_BAUD_DIV = 868;
  localparam logic        UART_IDLE_LEVEL       = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_e;

  // Even parity over one data byte.
  function automatic logic uart_even_parity(input logic [UART_DATA_BITS-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Single-clock first-word-fall-through byte FIFO for the UART transmitter.
// Pointers carry one extra wrap bit so full and empty are told apart by the MSB.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter  int unsigned DEPTH = 16,
  parameter  int unsigned WIDTH = UART_DATA_BITS,
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count
);

  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             wr_en;
  logic             rd_en;

  // A simultaneous pop frees the slot, so a push into a full FIFO is legal then.
  assign wr_en = push & (~full | rd_en);
  assign rd_en = pop & ~empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (rd_en) rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= din;
  end

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign count = wr_ptr - rd_ptr;
  assign dout  = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/uart_tx_serializer.sv
// Bit-serial UART transmitter: FIFO-buffered bytes shifted out LSB first as 8N1/8N2 frames.
// Define UART_TX_PARITY_EN to insert an even parity bit (8E1/8E2).
module uart_tx_serializer
  import uart_pkg::*;
#(
  parameter  int unsigned BAUD_DIV   = UART_DEFAULT_BAUD_DIV,
  parameter  int unsigned FIFO_DEPTH = 16,
  parameter  int unsigned STOP_BITS  = 1,
  localparam int unsigned CW         = $clog2(FIFO_DEPTH)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      transmit,
  input  logic [UART_DATA_BITS-1:0] tx_byte,
  output logic                      tx_ready,
  output logic                      tx,
  output logic                      is_transmitting,
  output logic [CW:0]               fifo_count
);

  localparam int unsigned BW = $clog2(BAUD_DIV);
  localparam logic [BW-1:0] BAUD_LAST  = BW'(BAUD_DIV - 1);
  localparam logic [2:0]    DATA_LAST  = 3'(UART_DATA_BITS - 1);
  localparam logic [2:0]    STOP_LAST  = 3'(STOP_BITS - 1);

  uart_state_e               state;
  uart_state_e               state_d;
  logic [BW-1:0]             baud_cnt;
  logic [2:0]                bit_cnt;
  logic [UART_DATA_BITS-1:0] shift;
  logic                      baud_end;
  logic                      pop_c;
  logic                      tx_c;
  logic                      busy_c;
  logic                      fifo_full;
  logic                      fifo_empty;
  logic [UART_DATA_BITS-1:0] fifo_dout;
`ifdef UART_TX_PARITY_EN
  logic                      parity_q;
`endif

  uart_tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (UART_DATA_BITS)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (transmit),
    .din   (tx_byte),
    .pop   (pop_c),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign tx_ready = ~fifo_full | pop_c;
  assign baud_end = (baud_cnt == BAUD_LAST);

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_d;
  end

  // Next-state and FIFO pop decision
  always_comb begin
    state_d = state;
    pop_c   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!fifo_empty) begin
          pop_c   = 1'b1;
          state_d = ST_START;
        end
      end
      ST_START: begin
        if (baud_end) state_d = ST_DATA;
      end
      ST_DATA: begin
        if (baud_end && (bit_cnt == DATA_LAST)) begin
`ifdef UART_TX_PARITY_EN
          state_d = ST_PARITY;
`else
          state_d = ST_STOP;
`endif
        end
      end
`ifdef UART_TX_PARITY_EN
      ST_PARITY: begin
        if (baud_end) state_d = ST_STOP;
      end
`endif
      ST_STOP: begin
        // Back-to-back frames: reload straight into START with no idle gap.
        if (baud_end && (bit_cnt == STOP_LAST)) begin
          if (!fifo_empty) begin
            pop_c   = 1'b1;
            state_d = ST_START;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Line level and busy flag for the current state
  always_comb begin
    tx_c   = UART_IDLE_LEVEL;
    busy_c = 1'b1;
    case (state)
      ST_IDLE:   busy_c = 1'b0;
      ST_START:  tx_c   = 1'b0;
      ST_DATA:   tx_c   = shift[0];
`ifdef UART_TX_PARITY_EN
      ST_PARITY: tx_c   = parity_q;
`endif
      ST_STOP:   tx_c   = 1'b1;
      default: begin
        tx_c   = UART_IDLE_LEVEL;
        busy_c = 1'b0;
      end
    endcase
  end

  // Baud counter, bit counter and shift register
  always_ff @(posedge clk) begin
    if (rst) begin
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shift    <= '0;
    end else begin
      if (state == ST_IDLE || baud_end) baud_cnt <= '0;
      else                              baud_cnt <= baud_cnt + BW'(1);

      if (baud_end && state == ST_DATA) begin
        bit_cnt <= bit_cnt + 3'd1;
      end else if (baud_end && state == ST_STOP) begin
        bit_cnt <= (bit_cnt == STOP_LAST) ? 3'd0 : bit_cnt + 3'd1;
      end

      if (pop_c)                            shift <= fifo_dout;
      else if (baud_end && state == ST_DATA) shift <= shift >> 1;
    end
  end

`ifdef UART_TX_PARITY_EN
  // Parity captured alongside the byte so it is stable for the whole frame.
  always_ff @(posedge clk) begin
    if (rst)        parity_q <= 1'b0;
    else if (pop_c) parity_q <= uart_even_parity(fifo_dout);
  end
`endif

  // Registered line outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      tx              <= UART_IDLE_LEVEL;
      is_transmitting <= 1'b0;
    end else begin
      tx              <= tx_c;
      is_transmitting <= busy_c;
    end
  end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Scoreboard bench for uart_tx_serializer (BAUD_DIV=4, FIFO_DEPTH=4, STOP_BITS=1).
// A frame-timing model predicts every line cycle; a line decoder checks bytes against a queue.
module tb_uart_tx_serializer;

  localparam int unsigned B  = 4;
  localparam int unsigned D  = 4;
  localparam int unsigned SB = 1;
`ifdef UART_TX_PARITY_EN
  localparam int unsigned PB = 1;
`else
  localparam int unsigned PB = 0;
`endif
  localparam int F = int'((9 + SB + PB) * B);

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       transmit = 1'b0;
  logic [7:0] tx_byte = 8'h00;
  logic       tx_ready;
  logic       tx;
  logic       is_transmitting;
  logic [2:0] fifo_count;

  always #5 clk = ~clk;

  uart_tx_serializer #(
    .BAUD_DIV   (B),
    .FIFO_DEPTH (D),
    .STOP_BITS  (SB)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .transmit        (transmit),
    .tx_byte         (tx_byte),
    .tx_ready        (tx_ready),
    .tx              (tx),
    .is_transmitting (is_transmitting),
    .fifo_count      (fifo_count)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: queued bytes, byte on the line and cycles left in its frame
  logic [7:0] mq[$];
  logic [7:0] sb[$];
  logic [7:0] cur = 8'h00;
  int         rem = 0;
  logic       tx_e = 1'b1;
  logic       busy_e = 1'b0;
  int         cnt_e = 0;
  bit         model_valid = 0;
  int         epoch = 0;
  int         pops = 0;
  int         aborted = 0;
  int         hs = 0;
  int         frames = 0;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Level of the line at a given cycle offset within a frame carrying d
  function automatic logic bit_at(input logic [7:0] d, input int pos);
    int idx;
    idx = pos / int'(B);
    if (idx == 0) return 1'b0;
    if (idx <= 8) return d[idx-1];
    if (PB == 1 && idx == 9) return ^d;
    return 1'b1;
  endfunction

  // One clock: check last edge's outputs, drive inputs, advance the model over the next edge
  task automatic step(input logic r, input logic t, input logic [7:0] b);
    bit pop_now;
    @(negedge clk);
    pop_now = (rem <= 1) && (mq.size() > 0);
    if (model_valid) begin
      check("tx", int'(tx), int'(tx_e));
      check("is_transmitting", int'(is_transmitting), int'(busy_e));
      check("fifo_count", int'(fifo_count), cnt_e);
      check("tx_ready", int'(tx_ready), int'((mq.size() < D) || pop_now));
    end
    rst      = r;
    transmit = t;
    tx_byte  = b;
    if (r) begin
      if (rem > 0) aborted++;
      mq.delete();
      sb.delete();
      rem    = 0;
      tx_e   = 1'b1;
      busy_e = 1'b0;
      cnt_e  = 0;
      epoch++;
      model_valid = 1;
    end else begin
      if (t && tx_ready) hs++;
      busy_e = (rem > 0);
      tx_e   = (rem > 0) ? bit_at(cur, F - rem) : 1'b1;
      if (pop_now) begin
        cur = mq.pop_front();
        rem = F;
        pops++;
      end else if (rem > 0) begin
        rem--;
      end
      if (t && ((mq.size() < D) || pop_now)) begin
        mq.push_back(b);
        sb.push_back(b);
      end
      cnt_e = mq.size();
    end
  endtask

  // Line decoder: samples mid-bit and pops the scoreboard for each completed frame
  initial begin : monitor
    logic       prev;
    logic [7:0] d;
    logic [7:0] exp;
    logic       st;
    logic       pb;
    logic       sp;
    int         ep;
    prev = 1'b1;
    forever begin
      @(negedge clk);
      if (!rst && prev && tx === 1'b0) begin
        ep = epoch;
        repeat (B/2) @(negedge clk);
        st = tx;
        for (int i = 0; i < 8; i++) begin
          repeat (B) @(negedge clk);
          d[i] = tx;
        end
        pb = 1'b0;
        if (PB == 1) begin
          repeat (B) @(negedge clk);
          pb = tx;
        end
        repeat (B) @(negedge clk);
        sp = tx;
        if (ep == epoch) begin
          frames++;
          if (sb.size() == 0) begin
            check("unexpected_frame", int'(d), -1);
          end else begin
            exp = sb.pop_front();
            check("frame_byte", int'(d), int'(exp));
            check("start_bit", int'(st), 0);
            check("stop_bit", int'(sp), 1);
            if (PB == 1) check("parity_bit", int'(pb), int'(^exp));
          end
        end
      end
      prev = tx;
    end
  end

  initial begin : stim
    int lat;
    int busy_cyc;
    int peak;
    int hs0;
    int fr0;

    step(1'b1, 1'b0, 8'h00);
    step(1'b1, 1'b0, 8'h00);
    repeat (20) step(1'b0, 1'b0, 8'h00);

    // Single frame: latency and busy window
    step(1'b0, 1'b1, 8'h55);
    lat = 0;
    busy_cyc = 0;
    for (int i = 1; i <= 60; i++) begin
      step(1'b0, 1'b0, 8'h00);
      if (tx == 1'b0 && lat == 0) lat = i;
      if (is_transmitting) busy_cyc++;
    end
    check("start_latency", lat, 3);
    check("busy_cycles", busy_cyc, F);

    // Back-to-back frames
    peak = 0;
    step(1'b0, 1'b1, 8'hA5);
    step(1'b0, 1'b1, 8'h3C);
    step(1'b0, 1'b1, 8'hFF);
    for (int i = 0; i < 3*F + 20; i++) begin
      step(1'b0, 1'b0, 8'h00);
      if (int'(fifo_count) > peak) peak = int'(fifo_count);
    end
    check("fifo_peak", peak, 2);

    // Overfill: six consecutive writes
    hs0 = hs;
    fr0 = frames;
    for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 8'($urandom));
    repeat (6*F) step(1'b0, 1'b0, 8'h00);
    check("accepted_writes", hs - hs0, 5);
    check("overfill_frames", frames - fr0, 5);

    // Parity-sensitive bytes
    step(1'b0, 1'b1, 8'h07);
    step(1'b0, 1'b1, 8'h03);
    repeat (3*F) step(1'b0, 1'b0, 8'h00);

    // Reset mid-frame flushes everything
    step(1'b0, 1'b1, 8'h00);
    step(1'b0, 1'b1, 8'h81);
    repeat (16) step(1'b0, 1'b0, 8'h00);
    step(1'b1, 1'b0, 8'h00);
    fr0 = frames;
    repeat (100) step(1'b0, 1'b0, 8'h00);
    check("frames_after_reset", frames - fr0, 0);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      step(1'b0, ($urandom_range(0, 2) == 0), 8'($urandom));
    end
    repeat (8*F) step(1'b0, 1'b0, 8'h00);

    check("scoreboard_drained", sb.size(), 0);
    check("frame_total", frames, pops - aborted);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
